// File: rtl/sized_mem_ctrl.sv
// sized_mem_ctrl: byte-addressed little-endian RV32 data memory with sized loads/stores,
// wait states and a single-outstanding valid/ready request/response handshake.
module sized_mem_ctrl #(
    parameter int DEPTH_BYTES = 8192,
    parameter int WAIT_CYCLES = 1,
    parameter bit ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic wr_q, uns_q;
    logic [1:0] size_q;
    logic [31:0] addr_q, wdata_q;
    logic [7:0] mem [DEPTH_BYTES];
    logic fire, done, err, we;
    logic [2:0] nbytes;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    logic [31:0] load_data;
    assign req_ready = (state == IDLE) && !rst;
    assign fire = req_valid && req_ready;
    // WAIT always spans WAIT_CYCLES+1 edges, so the response rises WAIT_CYCLES+1 edges after accept
    assign done = (state == WAIT) && (cnt == 4'(WAIT_CYCLES));
    assign we = done && wr_q && !err;
    assign nbytes = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
    assign err = (size_q == 2'd3)
        || (({1'b0, addr_q} + 33'(nbytes)) > 33'(DEPTH_BYTES))
        || (ALIGN_CHECK && ((size_q == 2'd1 && addr_q[0]) || (size_q == 2'd2 && addr_q[1:0] != 2'd0)));
    assign a0 = addr_q[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];
    assign load_data = (size_q == 2'd0) ? {{24{b0[7] & !uns_q}}, b0}
                     : (size_q == 2'd1) ? {{16{b1[7] & !uns_q}}, b1, b0}
                     : {b3, b2, b1, b0};
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire) state_nxt = WAIT;
            WAIT:    if (done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT && !done) ? cnt + 4'd1 : 4'd0;
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || wr_q) ? 32'd0 : load_data;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end
    // request latch and storage array are never reset; reset keeps state out of WAIT so no store fires
    always_ff @(posedge clk) begin
        if (fire) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (we) begin
            mem[a0] <= wdata_q[7:0];
            if (size_q != 2'd0) mem[a1] <= wdata_q[15:8];
            if (size_q == 2'd2) begin
                mem[a2] <= wdata_q[23:16];
                mem[a3] <= wdata_q[31:24];
            end
        end
    end
endmodule
